bsg_cache_dma_to_axil: RTL



---
 rtl/bp_arty_axil_pkg.sv | 26 ++
 rtl/bsg_counter_clear_up.sv | 49 ++++
 rtl/bsg_cache_dma_to_axil.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bp_arty_axil_pkg.sv
// Shared types and constants for the bsg_cache DMA to AXI4-Lite bridge.
//   axil_state_e        : bridge FSM states
//   axil_resp_okay      : AXI OKAY response code
//   bsg_cache_dma_pkt_s : bsg_cache DMA packet {write_not_read, addr}
package bp_arty_axil_pkg;

  // DMA packet address width used by bp_unicore's bsg_cache.
  localparam int dma_daddr_width_gp = 32;

  localparam logic [1:0] axil_resp_okay = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } axil_state_e;

  // Equivalent of declare_bsg_cache_dma_pkt_s(dma_daddr_width_gp).
  typedef struct packed {
    logic                          write_not_read;
    logic [dma_daddr_width_gp-1:0] addr;
  } bsg_cache_dma_pkt_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear, wrapping to zero after max_val_p.
//   clk_i     : clock
//   reset_n_i : synchronous active-low reset (count -> 0)
//   clear_i   : force count to 0 (has priority over up_i)
//   up_i      : increment by one
//   count_o   : current count (registered)
module bsg_counter_clear_up #(
  parameter int max_val_p = 7,
  parameter int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

  logic [width_lp-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step and wrap at max_lp.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i) begin
      if (count_q == max_lp) begin
        count_d = '0;
      end else begin
        count_d = count_q + width_lp'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_cache_dma_to_axil.sv
// Bridges the bsg_cache DMA interface (packet, fill data out, evict data in)
// onto single-beat AXI4-Lite master transactions, one outstanding at a time.
// Each packet becomes beats_lp consecutive reads or writes of data_width_p
// bits covering the addressed cache block.
//   clk_i, reset_n_i                      : clock, synchronous active-low reset
//   dma_pkt_*                             : packet {write_not_read, addr}, valid/yumi
//   dma_data_o/_v_o/_ready_and_i          : fill data toward the cache
//   dma_data_i/_v_i/_yumi_o               : evict data from the cache
//   ar*/r*/aw*/w*/b*                      : AXI4-Lite master channels
//   error_o                               : sticky, set by any non-OKAY response
module bsg_cache_dma_to_axil
  import bp_arty_axil_pkg::*;
#(
  parameter int daddr_width_p    = 32,
  parameter int data_width_p     = 64,
  parameter int block_width_p    = 512,
  parameter int axi_addr_width_p = 28
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [daddr_width_p:0]      dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,

  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_and_i,

  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o,

  output logic [axi_addr_width_p-1:0] araddr_o,
  output logic [2:0]                  arprot_o,
  output logic                        arvalid_o,
  input  logic                        arready_i,

  input  logic [data_width_p-1:0]     rdata_i,
  input  logic [1:0]                  rresp_i,
  input  logic                        rvalid_i,
  output logic                        rready_o,

  output logic [axi_addr_width_p-1:0] awaddr_o,
  output logic [2:0]                  awprot_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,

  output logic [data_width_p-1:0]     wdata_o,
  output logic [data_width_p/8-1:0]   wstrb_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,

  input  logic [1:0]                  bresp_i,
  input  logic                        bvalid_i,
  output logic                        bready_o,

  output logic                        error_o
);

  localparam int beats_lp     = block_width_p / data_width_p;
  localparam int lg_beats_lp  = $clog2(beats_lp);
  localparam int byte_off_lp  = $clog2(data_width_p / 8);
  localparam int block_off_lp = $clog2(block_width_p / 8);

  localparam logic [lg_beats_lp-1:0] last_beat_lp = lg_beats_lp'(beats_lp - 1);

  axil_state_e        state_q, state_d;
  bsg_cache_dma_pkt_s pkt_q, pkt_d, pkt_in;
  logic               error_q, error_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic                   cnt_clear, cnt_up;
  logic [lg_beats_lp-1:0] beat_q;
  logic                   last_beat;
  logic                   aw_fire, w_fire;
  logic                   aw_done_now, w_done_now;
  logic [axi_addr_width_p-1:0] beat_addr;
  logic                   unused_addr_bits;

  assign pkt_in    = dma_pkt_i;
  assign last_beat = (beat_q == last_beat_lp);

  // Block-aligned base with the beat index in place of the block offset;
  // packet address bits above the AXI address width are discarded.
  assign beat_addr = {pkt_q.addr[axi_addr_width_p-1:block_off_lp], beat_q,
                      {byte_off_lp{1'b0}}};
  assign unused_addr_bits = ^{pkt_q.addr[daddr_width_p-1:axi_addr_width_p],
                              pkt_q.addr[block_off_lp-1:0]};

  assign araddr_o   = beat_addr;
  assign awaddr_o   = beat_addr;
  assign arprot_o   = 3'b000;
  assign awprot_o   = 3'b000;
  assign dma_data_o = rdata_i;
  assign wdata_o    = dma_data_i;
  assign wstrb_o    = {(data_width_p/8){1'b1}};
  assign error_o    = error_q;

  bsg_counter_clear_up #(
    .max_val_p(beats_lp - 1)
  ) beat_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (cnt_clear),
    .up_i     (cnt_up),
    .count_o  (beat_q)
  );

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d         = state_q;
    pkt_d           = pkt_q;
    error_d         = error_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    cnt_clear       = 1'b0;
    cnt_up          = 1'b0;
    aw_fire         = 1'b0;
    w_fire          = 1'b0;
    aw_done_now     = aw_done_q;
    w_done_now      = w_done_q;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_v_o    = 1'b0;
    dma_data_yumi_o = 1'b0;
    arvalid_o       = 1'b0;
    rready_o        = 1'b0;
    awvalid_o       = 1'b0;
    wvalid_o        = 1'b0;
    bready_o        = 1'b0;

    case (state_q)
      IDLE: begin
        dma_pkt_yumi_o = dma_pkt_v_i;
        if (dma_pkt_v_i) begin
          pkt_d     = pkt_in;
          cnt_clear = 1'b1;
          state_d   = pkt_in.write_not_read ? WR_REQ : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end

      RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end

      RD_DATA: begin
        // R is only accepted when the cache can take the fill word, so a
        // stalled word stays on rdata_i until it is delivered.
        dma_data_v_o = rvalid_i;
        rready_o     = dma_data_ready_and_i;
        if (rvalid_i && dma_data_ready_and_i) begin
          if (rresp_i != axil_resp_okay) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          cnt_up  = 1'b1;
          state_d = last_beat ? IDLE : RD_ADDR;
        end else begin
          state_d = RD_DATA;
        end
      end

      WR_REQ: begin
        // AW and W complete independently; each valid drops only after its
        // own handshake, tracked by the done flags.
        awvalid_o       = !aw_done_q;
        wvalid_o        = dma_data_v_i && !w_done_q;
        aw_fire         = awvalid_o && awready_i;
        w_fire          = wvalid_o && wready_i;
        dma_data_yumi_o = w_fire;
        aw_done_now     = aw_done_q || aw_fire;
        w_done_now      = w_done_q || w_fire;
        if (aw_done_now && w_done_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_done_now;
          w_done_d  = w_done_now;
          state_d   = WR_REQ;
        end
      end

      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          if (bresp_i != axil_resp_okay) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          cnt_up  = 1'b1;
          state_d = last_beat ? IDLE : WR_REQ;
        end else begin
          state_d = WR_RESP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, packet, error and write-progress registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      error_q   <= error_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
